// File: rtl/buffer_bus_elastic.sv
// Elastic FIFO between two request/acknowledge handshake buses.
// PHASES selects return-to-zero (4) or transition (2) signalling on both sides.
module buffer_bus_elastic #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PHASES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a,
  input  logic                       lr_a_i,
  output logic                       la_a_i,
  output logic [WIDTH-1:0]           b,
  output logic                       rr_b_i,
  input  logic                       ra_b_i,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          TwoPhase = (PHASES == 2);

  typedef enum logic [1:0] {StIdle, StReq, StRtz} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             la_q, la_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic pending, accept, ack_idle, offer, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer refuses new words even when a pop happens on the same edge.
  always_comb begin
    pending  = TwoPhase ? (lr_a_i ^ la_q) : (lr_a_i & ~la_q);
    accept   = pending && (count_q < CW'(DEPTH));
    ack_idle = TwoPhase ? (ra_b_i == rr_q) : ~ra_b_i;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if ((count_q != '0) && ack_idle) state_d = StReq;
      StReq:   if (pop) state_d = TwoPhase ? StIdle : StRtz;
      StRtz:   if (!ra_b_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath strobes
  always_comb begin
    offer = (state_q == StIdle) && (count_q != '0) && ack_idle;
    pop   = (state_q == StReq) && (TwoPhase ? (ra_b_i == rr_q) : ra_b_i);

    rr_d = rr_q;
    if (offer) begin
      rr_d = TwoPhase ? ~rr_q : 1'b1;
    end else if (pop && !TwoPhase) begin
      rr_d = 1'b0;
    end

    b_d = offer ? mem_q[rd_ptr_q] : b_q;

    la_d = la_q;
    if (accept) begin
      la_d = TwoPhase ? ~la_q : 1'b1;
    end else if (!TwoPhase && !lr_a_i && la_q) begin
      la_d = 1'b0;
    end

    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      la_q     <= 1'b0;
      rr_q     <= 1'b0;
      b_q      <= '0;
    end else begin
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      la_q    <= la_d;
      rr_q    <= rr_d;
      b_q     <= b_d;
    end
  end

  // Storage contents need no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= a;
  end

  assign la_a_i = la_q;
  assign rr_b_i = rr_q;
  assign b      = b_q;
  assign count  = count_q;

endmodule
